// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

   // Responder control states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Legal byte-lane masks
   localparam logic [3:0] MASK_B0 = 4'b0001;
   localparam logic [3:0] MASK_B1 = 4'b0010;
   localparam logic [3:0] MASK_B2 = 4'b0100;
   localparam logic [3:0] MASK_B3 = 4'b1000;
   localparam logic [3:0] MASK_H0 = 4'b0011;
   localparam logic [3:0] MASK_H1 = 4'b1100;
   localparam logic [3:0] MASK_W  = 4'b1111;

   // Request captured at acceptance; word is the byte address with [1:0] dropped
   typedef struct packed {
      logic [29:0] word;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        sign;
      logic        store;
      logic        both;
   } req_t;

   // Extend a byte to 32 bits
   function automatic logic [31:0] ext8(input logic [7:0] b, input logic sign);
      return {{24{sign & b[7]}}, b};
   endfunction

   // Extend a halfword to 32 bits
   function automatic logic [31:0] ext16(input logic [15:0] h, input logic sign);
      return {{16{sign & h[15]}}, h};
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load lane select: pick the masked lanes, shift them to bit 0, extend.
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic [31:0] word,
   input  logic [3:0]  mask,
   input  logic        sign,
   output logic [31:0] data,
   output logic        illegal
);

   // Decode mask into aligned, extended data or flag it illegal
   always_comb begin
      data    = '0;
      illegal = 1'b0;
      case (mask)
         MASK_B0: data = ext8(word[7:0], sign);
         MASK_B1: data = ext8(word[15:8], sign);
         MASK_B2: data = ext8(word[23:16], sign);
         MASK_B3: data = ext8(word[31:24], sign);
         MASK_H0: data = ext16(word[15:0], sign);
         MASK_H1: data = ext16(word[31:16], sign);
         MASK_W:  data = word;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts EXU load/store, waits LATENCY cycles, responds.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] memAddr,
   input  logic [31:0] memData,
   input  logic        readWr,
   input  logic        writeWr,
   input  logic [3:0]  rmask,
   input  logic [3:0]  wmask,
   input  logic        rsign,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   req_t               req_q, req_nxt;
   logic               stall_raw;
   logic               enter_resp;
   logic [31:0]        mem [DEPTH];
   logic [IDX_W-1:0]   idx;
   logic               oob;
   logic [31:0]        rd_word;
   logic [31:0]        aligned;
   logic               mask_bad;
   logic               do_write;
   logic [31:0]        rdata_nxt;
   logic               err_nxt;
   logic               unused_addr_lsb;

   // Byte offset within the word is ignored; lanes come from the mask
   assign unused_addr_lsb = ^memAddr[1:0];

   // Next-state, counter and request capture
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_nxt    = req_q;
      stall_raw  = 1'b0;
      enter_resp = 1'b0;
      case (state)
         S_IDLE: begin
            if (readWr || writeWr) begin
               stall_raw     = 1'b1;
               req_nxt.word  = memAddr[31:2];
               req_nxt.data  = memData;
               req_nxt.mask  = writeWr ? wmask : rmask;
               req_nxt.sign  = rsign;
               req_nxt.store = writeWr;
               req_nxt.both  = readWr & writeWr;
               cnt_nxt       = CNT_W'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_nxt  = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt  = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            stall_raw = 1'b1;
            cnt_nxt   = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nxt  = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // No back-pressure while held in reset
   assign stall = stall_raw & rst;

   // Response datapath evaluated on the request that is about to complete
   assign idx = req_nxt.word[IDX_W-1:0];
   assign oob = |req_nxt.word[29:IDX_W];
   assign rd_word = mem[idx];

   dmem_lane_align u_align (
      .word    (rd_word),
      .mask    (req_nxt.mask),
      .sign    (req_nxt.sign),
      .data    (aligned),
      .illegal (mask_bad)
   );

   // Error classification, write enable and load result
   always_comb begin
      err_nxt   = req_nxt.both | mask_bad | oob;
      do_write  = enter_resp & req_nxt.store & ~mask_bad & ~oob;
      rdata_nxt = (!req_nxt.store && !mask_bad && !oob) ? aligned : '0;
   end

   // State, counter, request latch and registered response outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         req_q     <= '0;
         rsp_valid <= 1'b0;
         rdata     <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_q     <= req_nxt;
         rsp_valid <= enter_resp;
         if (enter_resp) begin
            rdata <= rdata_nxt;
            err   <= err_nxt;
         end
      end
   end

   // Byte-enabled store into the word array; contents survive reset
   always_ff @(posedge clk) begin
      if (rst && do_write) begin
         for (int b = 0; b < 4; b++) begin
            if (req_nxt.mask[b]) mem[idx][8*b +: 8] <= req_nxt.data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) against a byte-level model.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;

   typedef struct {
      int          due;
      logic [31:0] d;
      logic        e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst  [2];
   logic [31:0] addr [2];
   logic [31:0] data [2];
   logic        rd   [2];
   logic        wr   [2];
   logic [3:0]  rm   [2];
   logic [3:0]  wm   [2];
   logic        sg   [2];
   logic        stl  [2];
   logic        rv   [2];
   logic [31:0] rdat [2];
   logic        er   [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] mm [2][DEPTH];
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst[0]), .memAddr(addr[0]), .memData(data[0]),
      .readWr(rd[0]), .writeWr(wr[0]), .rmask(rm[0]), .wmask(wm[0]), .rsign(sg[0]),
      .stall(stl[0]), .rsp_valid(rv[0]), .rdata(rdat[0]), .err(er[0]));

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst[1]), .memAddr(addr[1]), .memData(data[1]),
      .readWr(rd[1]), .writeWr(wr[1]), .rmask(rm[1]), .wmask(wm[1]), .rsign(sg[1]),
      .stall(stl[1]), .rsp_valid(rv[1]), .rdata(rdat[1]), .err(er[1]));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Spec-level model: legality, range, lane merge, shift-and-extend arithmetic
   task automatic model(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input bit s,
                        output logic [31:0] od, output logic oe);
      bit          legal;
      bit          inr;
      int          n;
      int          lo;
      int          ix;
      logic [31:0] v;
      logic [31:0] keep;
      legal = (m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
      inr   = (a < 32'(4 * DEPTH));
      oe    = (r && w) || !legal || !inr;
      od    = '0;
      ix    = int'(a >> 2) % DEPTH;
      if (legal && inr) begin
         if (w) begin
            for (int b = 0; b < 4; b++)
               if (m[b]) mm[i][ix][8*b +: 8] = d[8*b +: 8];
         end else begin
            n  = $countones(m);
            lo = 0;
            while (!m[lo]) lo++;
            v = mm[i][ix] >> (8 * lo);
            if (n < 4) begin
               keep = (32'h1 << (8 * n)) - 32'h1;
               v    = v & keep;
               if (s && v[8*n-1]) v = v | ~keep;
            end
            od = v;
         end
      end
   endtask

   // Issue one request (called one tick after a posedge), hold it through RESP
   task automatic do_req(input int i, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input bit s,
                         input bit pin, input logic [31:0] pd, input logic pe,
                         input string nm);
      logic [31:0] od;
      logic        oe;
      exp_t        x;
      int          lat;
      lat = (i == 0) ? 2 : 1;
      model(i, r, w, a, d, m, s, od, oe);
      if (pin) begin
         check({nm, " model rdata"}, od, pd);
         check({nm, " model err"}, 32'(oe), 32'(pe));
      end
      x.due = cyc + lat;
      x.d   = od;
      x.e   = oe;
      if (i == 0) q0.push_back(x); else q1.push_back(x);
      addr[i] = a;
      data[i] = d;
      rd[i]   = r;
      wr[i]   = w;
      rm[i]   = w ? 4'b0101 : m;
      wm[i]   = w ? m : 4'b0101;
      sg[i]   = s;
      #1;
      check({nm, " stall on request"}, 32'(stl[i]), 32'd1);
      repeat (lat) @(posedge clk);
      #1;
      check({nm, " stall in resp"}, 32'(stl[i]), 32'd0);
      @(posedge clk);
      #1;
      rd[i] = 1'b0;
      wr[i] = 1'b0;
   endtask

   // Every cycle: rsp_valid must match the model schedule, data/err on responses
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         bit   have;
         exp_t h;
         have = 1'b0;
         h    = '{0, 32'h0, 1'b0};
         if (i == 0 && q0.size() > 0 && q0[0].due == cyc) begin have = 1'b1; h = q0[0]; void'(q0.pop_front()); end
         if (i == 1 && q1.size() > 0 && q1[0].due == cyc) begin have = 1'b1; h = q1[0]; void'(q1.pop_front()); end
         check($sformatf("rsp_valid[%0d]", i), 32'(rv[i]), 32'(have));
         if (have) begin
            check($sformatf("rdata[%0d]", i), rdat[i], h.d);
            check($sformatf("err[%0d]", i), 32'(er[i]), 32'(h.e));
         end
      end
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b0; addr[i] = '0; data[i] = '0; rd[i] = 1'b1; wr[i] = 1'b0;
         rm[i] = 4'hF; wm[i] = 4'hF; sg[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset stall[%0d]", i), 32'(stl[i]), 32'd0);
         check($sformatf("reset rsp_valid[%0d]", i), 32'(rv[i]), 32'd0);
         check($sformatf("reset rdata[%0d]", i), rdat[i], 32'd0);
         check($sformatf("reset err[%0d]", i), 32'(er[i]), 32'd0);
         rd[i]  = 1'b0;
         rst[i] = 1'b1;
      end
      @(posedge clk); #1;

      // LATENCY=2: word, byte, half, error cases
      do_req(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0, 1'b0, "sw");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'hF, 0, 1, 32'hDEADBEEF, 1'b0, "lw");
      do_req(0, 0, 1, 32'h10, 32'h00800000, 4'h4, 0, 1, 32'h0, 1'b0, "sb");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h4, 1, 1, 32'hFFFFFF80, 1'b0, "lb");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h4, 0, 1, 32'h00000080, 1'b0, "lbu");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'hF, 0, 1, 32'hDE80BEEF, 1'b0, "lw2");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'hC, 1, 1, 32'hFFFFDE80, 1'b0, "lh");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h3, 0, 1, 32'h0000BEEF, 1'b0, "lhu");
      do_req(0, 1, 0, 32'h13, 32'h0, 4'h8, 1, 1, 32'hFFFFFFDE, 1'b0, "lb lsb ignored");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'h5, 1, 1, 32'h0, 1'b1, "bad rmask");
      do_req(0, 0, 1, 32'h10, 32'h11111111, 4'h0, 0, 1, 32'h0, 1'b1, "zero wmask");
      do_req(0, 1, 0, 32'(4 * DEPTH), 32'h0, 4'hF, 0, 1, 32'h0, 1'b1, "lw oob");
      do_req(0, 0, 1, 32'(4 * DEPTH) + 32'h10, 32'h22222222, 4'hF, 0, 1, 32'h0, 1'b1, "sw oob");
      do_req(0, 1, 0, 32'h10, 32'h0, 4'hF, 0, 1, 32'hDE80BEEF, 1'b0, "lw after bad stores");
      do_req(0, 1, 1, 32'h20, 32'h12345678, 4'hF, 0, 1, 32'h0, 1'b1, "rd+wr");
      do_req(0, 1, 0, 32'h20, 32'h0, 4'hF, 0, 1, 32'h12345678, 1'b0, "lw rd+wr target");

      // LATENCY=1: fill four words, then four back-to-back loads
      for (int k = 0; k < 4; k++)
         do_req(1, 0, 1, 32'(4 * k), 32'hA0B0C0D0 + 32'(k), 4'hF, 0, 0, 32'h0, 1'b0, "l1 sw");
      do_req(1, 1, 0, 32'h0, 32'h0, 4'hF, 0, 1, 32'hA0B0C0D0, 1'b0, "l1 lw0");
      do_req(1, 1, 0, 32'h4, 32'h0, 4'h1, 1, 1, 32'hFFFFFFD1, 1'b0, "l1 lb1");
      do_req(1, 1, 0, 32'h8, 32'h0, 4'hC, 0, 1, 32'h0000A0B0, 1'b0, "l1 lhu2");
      do_req(1, 1, 0, 32'hC, 32'h0, 4'h2, 1, 1, 32'hFFFFFFC0, 1'b0, "l1 lb3");

      // Reset during BUSY of a store: request dropped, word untouched
      addr[0] = 32'h10; data[0] = 32'h55555555; wm[0] = 4'hF; rm[0] = 4'h5; wr[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0; wr[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1, 0, 32'h10, 32'h0, 4'hF, 0, 1, 32'hDE80BEEF, 1'b0, "lw after reset");

      repeat (3) @(posedge clk);
      #1;
      check("pending responses l2", 32'(q0.size()), 32'd0);
      check("pending responses l1", 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
